// File: rtl/scroll_pkg.sv
// -----------------------------------------------------------------------------
// scroll_pkg
// Shared constants for the two-digit character scroller: FSM state encoding,
// the default pad character, default timing for a 25 MHz board clock, and a
// small clog2 helper that never returns a zero width.
// -----------------------------------------------------------------------------
package scroll_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SCROLL = 2'd2;

    localparam logic [7:0]  PAD_CHAR_DEFAULT       = 8'h20;
    localparam int unsigned MSG_DEPTH_DEFAULT      = 16;
    localparam int unsigned TICKS_PER_STEP_DEFAULT = 6250000;  // 250 ms at 25 MHz

    // Width of a counter holding 0..v-1; at least one bit.
    function automatic int unsigned safeClog2(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/char_scroll_controller_if.sv
// -----------------------------------------------------------------------------
// char_scroll_controller_if
// Write port, control pulses and display outputs of the character scroller.
//   i_wr_valid/i_wr_char/i_wr_last/o_wr_ready : character append handshake
//   i_start/i_stop                            : scroll control pulses
//   o_busy/o_done                             : status
//   o_char_left/o_char_right                  : ASCII codes to the digit decoders
// master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface char_scroll_controller_if;

    logic       i_wr_valid;
    logic [7:0] i_wr_char;
    logic       i_wr_last;
    logic       o_wr_ready;
    logic       i_start;
    logic       i_stop;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_char_left;
    logic [7:0] o_char_right;

    modport master (
        output i_wr_valid, i_wr_char, i_wr_last, i_start, i_stop,
        input  o_wr_ready, o_busy, o_done, o_char_left, o_char_right
    );

    modport slave (
        input  i_wr_valid, i_wr_char, i_wr_last, i_start, i_stop,
        output o_wr_ready, o_busy, o_done, o_char_left, o_char_right
    );

endinterface

// File: rtl/scroll_tick_gen.sv
// -----------------------------------------------------------------------------
// scroll_tick_gen
// Free-running step timer: counts 0..TICKS_PER_STEP-1 while enabled and flags
// the last cycle of each step. Reusable for other display timers.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   i_en   : count enable
//   i_clr  : synchronous clear (wins over enable)
//   o_tick : high during the final cycle of a step (wrap cycle)
// -----------------------------------------------------------------------------
module scroll_tick_gen
    import scroll_pkg::*;
#(
    parameter int unsigned TICKS_PER_STEP = TICKS_PER_STEP_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned TW = safeClog2(TICKS_PER_STEP);
    localparam logic [TW-1:0] LAST_COUNT = TW'(TICKS_PER_STEP - 1);

    logic [TW-1:0] timer;

    // Step counter, wraps to zero after LAST_COUNT
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            timer <= '0;
        end else if (i_en) begin
            timer <= (timer == LAST_COUNT) ? '0 : timer + TW'(1);
        end
    end

    // Combinational so the caller can advance on the same edge the timer wraps
    assign o_tick = i_en && !i_clr && (timer == LAST_COUNT);

endmodule

// File: rtl/char_scroll_controller.sv
// -----------------------------------------------------------------------------
// char_scroll_controller
// Buffers a short ASCII message and scrolls it across two 7-segment digits,
// one character per step. Segment encoding is done downstream.
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   bus   : char_scroll_controller_if.slave (write port, start/stop, status,
//           left/right ASCII codes); all outputs registered
// Build option: define SCROLLER_LOOP_EN to repeat the scroll until i_stop.
// -----------------------------------------------------------------------------
module char_scroll_controller
    import scroll_pkg::*;
#(
    parameter int unsigned MSG_DEPTH      = MSG_DEPTH_DEFAULT,
    parameter int unsigned TICKS_PER_STEP = TICKS_PER_STEP_DEFAULT,
    parameter logic [7:0]  PAD_CHAR       = PAD_CHAR_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    char_scroll_controller_if.slave   bus
);

    localparam int unsigned AW = $clog2(MSG_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(MSG_DEPTH + 2);

    logic [1:0]    state, nextState;
    logic [CW-1:0] count, nextCount;
    logic [FW-1:0] frame, nextFrame, lastFrame, leftIdx;
    logic [7:0]    msgBuf [MSG_DEPTH];
    logic [7:0]    leftNext, rightNext;
    logic          wrAccept, doneNext, tick, tickEn, tickClr;

    // A stop in LOAD discards the message, so a coincident write is dropped
    assign wrAccept  = bus.i_wr_valid && bus.o_wr_ready && !(bus.i_stop && state == ST_LOAD);
    assign lastFrame = FW'(count) + FW'(1);
    assign leftIdx   = frame - FW'(1);
    assign tickEn    = (state == ST_SCROLL);
    assign tickClr   = (state != ST_SCROLL) || bus.i_stop;

    scroll_tick_gen #(
        .TICKS_PER_STEP (TICKS_PER_STEP)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (tickEn),
        .i_clr  (tickClr),
        .o_tick (tick)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state, message length and frame sequencing
    always_comb begin
        nextState = state;
        nextCount = count;
        nextFrame = frame;
        doneNext  = 1'b0;
        if (wrAccept) begin
            nextCount = count + CW'(1);
        end
        case (state)
            ST_IDLE: begin
                if (wrAccept) begin
                    nextState = bus.i_wr_last ? ST_SCROLL : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.i_stop) begin
                    nextState = ST_IDLE;
                    nextCount = '0;
                end else if ((wrAccept && bus.i_wr_last) || (bus.i_start && count != '0)) begin
                    nextState = ST_SCROLL;
                end
            end
            ST_SCROLL: begin
                if (bus.i_stop) begin
                    nextState = ST_IDLE;
                    nextCount = '0;
                    nextFrame = '0;
                end else if (tick) begin
                    if (frame == lastFrame) begin
                        doneNext  = 1'b1;
                        nextFrame = '0;
`ifdef SCROLLER_LOOP_EN
                        nextState = ST_SCROLL;
`else
                        nextState = ST_IDLE;
                        nextCount = '0;
`endif
                    end else begin
                        nextFrame = frame + FW'(1);
                    end
                end
            end
            default: begin
                nextState = ST_IDLE;
                nextCount = '0;
                nextFrame = '0;
            end
        endcase
    end

    // Frame k shows S[k-1] | S[k]; anything outside the message is padding
    always_comb begin
        leftNext  = PAD_CHAR;
        rightNext = PAD_CHAR;
        if (state == ST_SCROLL && nextState == ST_SCROLL) begin
            if (frame != '0 && leftIdx < FW'(count)) begin
                leftNext = msgBuf[AW'(leftIdx)];
            end
            if (frame < FW'(count)) begin
                rightNext = msgBuf[AW'(frame)];
            end
        end
    end

    // Message storage; contents are meaningless beyond count
    always_ff @(posedge i_clk) begin
        if (wrAccept) begin
            msgBuf[AW'(count)] <= bus.i_wr_char;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count            <= '0;
            frame            <= '0;
            bus.o_char_left  <= PAD_CHAR;
            bus.o_char_right <= PAD_CHAR;
            bus.o_busy       <= 1'b0;
            bus.o_done       <= 1'b0;
            bus.o_wr_ready   <= 1'b0;
        end else begin
            count            <= nextCount;
            frame            <= nextFrame;
            bus.o_char_left  <= leftNext;
            bus.o_char_right <= rightNext;
            bus.o_busy       <= (nextState == ST_SCROLL);
            bus.o_done       <= doneNext;
            bus.o_wr_ready   <= (nextState != ST_SCROLL) && (nextCount < CW'(MSG_DEPTH));
        end
    end

endmodule

// File: tb/tb_char_scroll_controller.sv
// -----------------------------------------------------------------------------
// tb_char_scroll_controller
// Directed bench for char_scroll_controller with TICKS_PER_STEP=4,
// MSG_DEPTH=16, PAD_CHAR=8'h20. Honours SCROLLER_LOOP_EN when defined.
// -----------------------------------------------------------------------------
module tb_char_scroll_controller;

    localparam int unsigned T   = 4;
    localparam int unsigned D   = 16;
    localparam logic [7:0]  PAD = 8'h20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   failCount  = 0;
    logic [7:0] msg [D];

    always #5 clk = ~clk;

    char_scroll_controller_if bus();

    char_scroll_controller #(
        .MSG_DEPTH      (D),
        .TICKS_PER_STEP (T),
        .PAD_CHAR       (PAD)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic writeChar(input logic [7:0] c, input logic last);
        checkVal("wr_ready_before_write", 32'(bus.o_wr_ready), 32'd1);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_char  = c;
        bus.i_wr_last  = last;
        nextCycle();
        bus.i_wr_valid = 1'b0;
        bus.i_wr_last  = 1'b0;
    endtask

    task automatic stopCheck();
        bus.i_stop = 1'b1;
        nextCycle();
        bus.i_stop = 1'b0;
        checkVal("stop_busy",     32'(bus.o_busy),       32'd0);
        checkVal("stop_done",     32'(bus.o_done),       32'd0);
        checkVal("stop_left",     32'(bus.o_char_left),  32'(PAD));
        checkVal("stop_right",    32'(bus.o_char_right), 32'(PAD));
        checkVal("stop_wr_ready", 32'(bus.o_wr_ready),   32'd1);
    endtask

    // Called just after the edge that moved the DUT into SCROLL
    task automatic runScroll(input int len, input int passes);
        int period;
        int k;
        logic [7:0] expL, expR;
        logic expBusy;
        period = (len + 2) * int'(T);
        checkVal("entry_busy",  32'(bus.o_busy),       32'd1);
        checkVal("entry_left",  32'(bus.o_char_left),  32'(PAD));
        checkVal("entry_right", 32'(bus.o_char_right), 32'(PAD));
        for (int n = 1; n <= passes * period; n++) begin
            nextCycle();
            k    = ((n - 1) / int'(T)) % (len + 2);
            expL = (k >= 1 && (k - 1) < len) ? msg[k - 1] : PAD;
            expR = (k < len) ? msg[k] : PAD;
`ifdef SCROLLER_LOOP_EN
            expBusy = 1'b1;
`else
            expBusy = (n < period);
`endif
            checkVal($sformatf("left_n%0d", n),  32'(bus.o_char_left),  32'(expL));
            checkVal($sformatf("right_n%0d", n), 32'(bus.o_char_right), 32'(expR));
            checkVal($sformatf("done_n%0d", n),  32'(bus.o_done),       32'((n % period) == 0));
            checkVal($sformatf("busy_n%0d", n),  32'(bus.o_busy),       32'(expBusy));
        end
`ifdef SCROLLER_LOOP_EN
        stopCheck();
`else
        nextCycle();
        checkVal("post_done",     32'(bus.o_done),       32'd0);
        checkVal("post_busy",     32'(bus.o_busy),       32'd0);
        checkVal("post_left",     32'(bus.o_char_left),  32'(PAD));
        checkVal("post_right",    32'(bus.o_char_right), 32'(PAD));
        checkVal("post_wr_ready", 32'(bus.o_wr_ready),   32'd1);
`endif
    endtask

    initial begin
        bus.i_wr_valid = 1'b0;
        bus.i_wr_char  = 8'h00;
        bus.i_wr_last  = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_stop     = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (3) nextCycle();
        checkVal("rst_left",  32'(bus.o_char_left),  32'(PAD));
        checkVal("rst_right", 32'(bus.o_char_right), 32'(PAD));
        checkVal("rst_busy",  32'(bus.o_busy),       32'd0);
        checkVal("rst_done",  32'(bus.o_done),       32'd0);
        rst = 1'b0;
        nextCycle();
        checkVal("rel_wr_ready", 32'(bus.o_wr_ready), 32'd1);
        checkVal("rel_busy",     32'(bus.o_busy),     32'd0);

        // "HI" terminated by last
        msg[0] = 8'h48;
        msg[1] = 8'h49;
        writeChar(8'h48, 1'b0);
        writeChar(8'h49, 1'b1);
        runScroll(2, 1);

        // Full buffer, overflow write ignored, explicit start
        for (int i = 0; i < int'(D); i++) begin
            msg[i] = 8'(8'h41 + i);
            writeChar(msg[i], 1'b0);
        end
        checkVal("full_wr_ready", 32'(bus.o_wr_ready), 32'd0);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_char  = 8'h58;
        repeat (2) begin
            nextCycle();
            checkVal("full_hold_ready", 32'(bus.o_wr_ready), 32'd0);
            checkVal("full_hold_busy",  32'(bus.o_busy),     32'd0);
        end
        bus.i_wr_valid = 1'b0;
        bus.i_start    = 1'b1;
        nextCycle();
        bus.i_start    = 1'b0;
        runScroll(16, 1);

        // Stop mid-frame 2 of "Ab"
        writeChar(8'h41, 1'b0);
        writeChar(8'h62, 1'b0);
        bus.i_start = 1'b1;
        nextCycle();
        bus.i_start = 1'b0;
        checkVal("ab_busy", 32'(bus.o_busy), 32'd1);
        repeat (2 * T + 1) nextCycle();
        checkVal("ab_f2_left",  32'(bus.o_char_left),  32'h62);
        checkVal("ab_f2_right", 32'(bus.o_char_right), 32'(PAD));
        stopCheck();
        repeat (3 * T) begin
            nextCycle();
            checkVal("ab_no_done", 32'(bus.o_done), 32'd0);
        end
        msg[0] = 8'h5A;
        writeChar(8'h5A, 1'b1);
        runScroll(1, 1);

        // Start with empty buffer is ignored
        bus.i_start = 1'b1;
        nextCycle();
        bus.i_start = 1'b0;
        checkVal("empty_start_busy", 32'(bus.o_busy), 32'd0);
        nextCycle();
        checkVal("empty_start_busy2", 32'(bus.o_busy),     32'd0);
        checkVal("empty_start_ready", 32'(bus.o_wr_ready), 32'd1);

        // Stop beats start and a write in LOAD
        writeChar(8'h51, 1'b0);
        checkVal("load_busy", 32'(bus.o_busy), 32'd0);
        bus.i_start    = 1'b1;
        bus.i_stop     = 1'b1;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_char  = 8'h52;
        bus.i_wr_last  = 1'b1;
        nextCycle();
        bus.i_start    = 1'b0;
        bus.i_stop     = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_last  = 1'b0;
        checkVal("ss_busy",  32'(bus.o_busy),     32'd0);
        checkVal("ss_ready", 32'(bus.o_wr_ready), 32'd1);
        nextCycle();
        checkVal("ss_busy2", 32'(bus.o_busy), 32'd0);
        msg[0] = 8'h4B;
        writeChar(8'h4B, 1'b1);
        runScroll(1, 1);

`ifdef SCROLLER_LOOP_EN
        // Repeating single-character message
        msg[0] = 8'h38;
        writeChar(8'h38, 1'b1);
        runScroll(1, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
